// File: rtl/imu_seq_pkg.sv
// Shared types and constants for the IMU SPI sequencer.
package imu_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    CS_IDLE
  } state_t;

  localparam logic [7:0]  SPI_READ_BIT = 8'h80;
  localparam int unsigned BYTE_W       = 8;

endpackage

// File: rtl/spi_sck_divider.sv
// Half-period tick generator: one-cycle tick every CLK_DIV cycles while enabled,
// count restarts from zero whenever the enable is low.
module spi_sck_divider #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_tick
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == CW'(CLK_DIV - 1));
  assign o_tick = i_en && w_last;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (!i_en || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/imu_spi_sequencer.sv
// Periodic SPI mode-3 burst reader that hands each sensor sample to the filter on valid/ready.
// Optional HOST_ARB_EN: defer launches to, and yield the bus to, a host master sharing it.
module imu_spi_sequencer
  import imu_seq_pkg::*;
#(
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned SAMPLE_PERIOD = 10000,
  parameter int unsigned NUM_BYTES     = 6,
  parameter logic [7:0]  START_ADDR    = 8'h28
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_en,
  input  logic                        i_spi_miso,
  input  logic                        i_host_cs_n,
  output logic                        o_spi_sck,
  output logic                        o_spi_mosi,
  output logic                        o_spi_cs_n,
  output logic                        o_spi_oe,
  output logic [BYTE_W*NUM_BYTES-1:0] o_sample_data,
  output logic                        o_sample_valid,
  input  logic                        i_sample_ready,
  output logic                        o_overrun,
  output logic                        o_collision
);

  localparam int unsigned DW     = BYTE_W * NUM_BYTES;
  localparam int unsigned HALVES = 16 * (NUM_BYTES + 1);
  localparam int unsigned HW     = $clog2(HALVES);
  localparam int unsigned PW     = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [7:0]  CMD    = SPI_READ_BIT | START_ADDR;

  state_t          r_state, w_state_d;
  logic [HW-1:0]   r_half, w_half_d;
  logic [PW-1:0]   r_period;
  logic [6:0]      r_byte;
  logic [DW-1:0]   r_rx, w_rx_next;
  logic [DW-1:0]   r_sample;
  logic            r_valid;
  logic            r_sck, r_mosi, r_cs_n, r_oe;
  logic            r_overrun, r_collision;
  logic            w_trigger, w_tick, w_div_en, w_slot_free;
  logic            w_launch, w_overrun, w_coll, w_rise, w_done;
  logic            r_pending, w_pending_d;

  assign w_trigger   = i_en && (r_period == PW'(SAMPLE_PERIOD - 1));
  assign w_slot_free = !r_valid || i_sample_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_period <= '0;
    end else if (!i_en || w_trigger) begin
      r_period <= '0;
    end else begin
      r_period <= r_period + 1'b1;
    end
  end

`ifdef HOST_ARB_EN
  logic r_host_s1, r_host_s2, r_discard;
  logic w_host_hi;

  assign w_host_hi = r_host_s2;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_host_s1 <= 1'b1;
      r_host_s2 <= 1'b1;
      r_discard <= 1'b0;
    end else begin
      r_host_s1 <= i_host_cs_n;
      r_host_s2 <= r_host_s1;
      if (w_coll) begin
        r_discard <= 1'b1;
      end else if (w_launch) begin
        r_discard <= 1'b0;
      end
    end
  end
`else
  logic w_host_unused;
  assign w_host_unused = i_host_cs_n;
`endif

  // Held in reset across state changes forced by a collision so CS_IDLE gets a full period.
  assign w_div_en = (r_state != IDLE) && !w_coll;

  spi_sck_divider #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (w_div_en),
    .o_tick (w_tick)
  );

  always_comb begin
    w_state_d   = r_state;
    w_half_d    = r_half;
    w_pending_d = r_pending;
    w_launch    = 1'b0;
    w_overrun   = 1'b0;
    w_coll      = 1'b0;
    unique case (r_state)
      IDLE: begin
`ifdef HOST_ARB_EN
        if (r_pending) begin
          w_overrun = w_trigger;
          w_launch  = w_host_hi;
        end else if (w_trigger) begin
          if (!w_slot_free) begin
            w_overrun = 1'b1;
          end else if (w_host_hi) begin
            w_launch = 1'b1;
          end else begin
            w_pending_d = 1'b1;
          end
        end
`else
        if (w_trigger) begin
          if (w_slot_free) begin
            w_launch = 1'b1;
          end else begin
            w_overrun = 1'b1;
          end
        end
`endif
        if (w_launch) begin
          w_state_d   = CS_SETUP;
          w_half_d    = '0;
          w_pending_d = 1'b0;
        end
      end
      CS_SETUP: if (w_tick) w_state_d = SHIFT;
      SHIFT: begin
        if (w_tick) begin
          if (r_half == HW'(HALVES - 1)) begin
            w_state_d = CS_HOLD;
          end else begin
            w_half_d = r_half + 1'b1;
          end
        end
      end
      CS_HOLD: if (w_tick) w_state_d = CS_IDLE;
      CS_IDLE: if (w_tick) w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
    if (r_state != IDLE) begin
      w_overrun = w_trigger;
    end
`ifdef HOST_ARB_EN
    if ((r_state inside {CS_SETUP, SHIFT, CS_HOLD}) && !w_host_hi) begin
      w_coll    = 1'b1;
      w_state_d = CS_IDLE;
    end
`endif
  end

  // Even half-periods hold SCK low; the tick ending one is the rising (sampling) edge.
  assign w_rise = (r_state == SHIFT) && w_tick && !r_half[0];
  assign w_done = (r_state == CS_IDLE) && w_tick;

  // Each completed byte enters at the top so the first byte ends up in [7:0].
  if (NUM_BYTES == 1) begin : g_rx_one
    assign w_rx_next = {r_byte, i_spi_miso};
  end else begin : g_rx_many
    assign w_rx_next = {r_byte, i_spi_miso, r_rx[DW-1:BYTE_W]};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_half      <= '0;
      r_pending   <= 1'b0;
      r_byte      <= '0;
      r_rx        <= '0;
      r_sample    <= '0;
      r_valid     <= 1'b0;
      r_sck       <= 1'b1;
      r_mosi      <= 1'b0;
      r_cs_n      <= 1'b1;
      r_oe        <= 1'b0;
      r_overrun   <= 1'b0;
      r_collision <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_half      <= w_half_d;
      r_pending   <= w_pending_d;
      r_overrun   <= w_overrun;
      r_collision <= w_coll;
      if (w_rise && (r_half >= HW'(16))) begin
        r_byte <= {r_byte[5:0], i_spi_miso};
        if (r_half[3:1] == 3'b111) begin
          r_rx <= w_rx_next;
        end
      end
`ifdef HOST_ARB_EN
      if (w_done && !r_discard) begin
`else
      if (w_done) begin
`endif
        r_sample <= r_rx;
        r_valid  <= 1'b1;
      end else if (r_valid && i_sample_ready) begin
        r_valid <= 1'b0;
      end
      r_cs_n <= !(w_state_d inside {CS_SETUP, SHIFT, CS_HOLD});
      r_sck  <= (w_state_d == SHIFT) ? w_half_d[0] : 1'b1;
      r_mosi <= ((w_state_d == SHIFT) && (w_half_d < HW'(16))) ?
                CMD[3'd7 - w_half_d[3:1]] : 1'b0;
`ifdef HOST_ARB_EN
      r_oe   <= (w_state_d != IDLE);
`else
      r_oe   <= 1'b1;
`endif
    end
  end

  assign o_spi_sck      = r_sck;
  assign o_spi_mosi     = r_mosi;
  assign o_spi_cs_n     = r_cs_n;
  assign o_spi_oe       = r_oe;
  assign o_sample_data  = r_sample;
  assign o_sample_valid = r_valid;
  assign o_overrun      = r_overrun;
  assign o_collision    = r_collision;

endmodule
